// File: rtl/d16_dbus_arbiter.sv
// Shares the single synchronous data RAM port between the d16 core and a burst DMA requester.
// The core always wins; DMA beats fill the cycles where the core makes no data access.
module d16_dbus_arbiter #(
  parameter int STARVE_MAX = 255,
  parameter int CNT_W      = 16
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        core_re,
  input  logic        core_we,
  input  logic [15:0] core_a,
  input  logic [15:0] core_do,
  output logic [15:0] core_di,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [15:0] dma_a,
  input  logic [7:0]  dma_len,
  input  logic [15:0] dma_do,
  output logic        dma_ack,
  output logic        dma_rvalid,
  output logic [15:0] dma_di,
  output logic        dma_busy,
  output logic        dma_done,
  output logic        dma_starve,
  output logic [15:0] mem_a,
  output logic        mem_we,
  output logic [15:0] mem_do,
  input  logic [15:0] mem_di
);

  typedef enum logic {IDLE, BURST} state_t;

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  state_t           state_reg;
  logic [15:0]      base_reg;
  logic             dir_reg;
  logic [7:0]       remaining_reg;
  logic [7:0]       idx_reg;
  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             rvalid_reg;
  logic             done_reg;
  logic             starve_reg;

  logic             core_act;
  logic             beat;

  assign core_act = core_re | core_we;
  assign beat     = (state_reg == BURST) && !core_act;

  // A simultaneous read+write from the core falls out as a write because mem_we follows core_we.
  assign mem_a  = beat ? (base_reg + {8'h00, idx_reg}) : core_a;
  assign mem_we = beat ? dir_reg : core_we;
  assign mem_do = beat ? dma_do : core_do;

  assign core_di    = mem_di;
  assign dma_di     = mem_di;
  assign dma_ack    = beat;
  assign dma_busy   = (state_reg == BURST);
  assign dma_rvalid = rvalid_reg;
  assign dma_done   = done_reg;
  assign dma_starve = starve_reg;

  always_comb begin
    starve_cnt_next = '0;
    if (state_reg == BURST && core_act) begin
      starve_cnt_next = (starve_cnt_reg == STARVE_LIM) ? starve_cnt_reg
                                                       : starve_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= IDLE;
      base_reg       <= '0;
      dir_reg        <= 1'b0;
      remaining_reg  <= '0;
      idx_reg        <= '0;
      starve_cnt_reg <= '0;
      rvalid_reg     <= 1'b0;
      done_reg       <= 1'b0;
      starve_reg     <= 1'b0;
    end else begin
      rvalid_reg     <= beat && !dir_reg;
      done_reg       <= beat && (remaining_reg == 8'd0);
      starve_cnt_reg <= starve_cnt_next;
      starve_reg     <= (starve_cnt_next == STARVE_LIM);
      case (state_reg)
        IDLE: begin
          if (dma_req) begin
            base_reg      <= dma_a;
            dir_reg       <= dma_we;
            remaining_reg <= dma_len;
            idx_reg       <= 8'd0;
            state_reg     <= BURST;
          end
        end
        BURST: begin
          if (beat) begin
            idx_reg       <= idx_reg + 8'd1;
            remaining_reg <= remaining_reg - 8'd1;
            if (remaining_reg == 8'd0) begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d16_dbus_arbiter.sv
// Bench for d16_dbus_arbiter: vector table, hand-written corner sequences and a randomized
// run checked against a queue-based burst model, with a synchronous RAM model on the memory port.
module tb_d16_dbus_arbiter;

  localparam int SM = 4;

  typedef struct {
    logic        rst, re, we;
    logic [15:0] ca, cd;
    logic        req, dwe;
    logic [15:0] da;
    logic [7:0]  dl;
    logic [15:0] ddo;
  } in_t;

  typedef struct {
    in_t         vi;
    logic        ack;
    logic [15:0] ma;
    logic        mwe;
    logic [15:0] mdo;
    logic        busy;
    logic        done;
  } vec_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic        core_re, core_we;
  logic [15:0] core_a, core_do, core_di;
  logic        dma_req, dma_we;
  logic [15:0] dma_a;
  logic [7:0]  dma_len;
  logic [15:0] dma_do;
  logic        dma_ack, dma_rvalid, dma_busy, dma_done, dma_starve;
  logic [15:0] dma_di;
  logic [15:0] mem_a, mem_do;
  logic        mem_we;
  logic [15:0] mem_di;

  d16_dbus_arbiter #(.STARVE_MAX(SM), .CNT_W(16)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .core_re(core_re), .core_we(core_we), .core_a(core_a), .core_do(core_do), .core_di(core_di),
    .dma_req(dma_req), .dma_we(dma_we), .dma_a(dma_a), .dma_len(dma_len), .dma_do(dma_do),
    .dma_ack(dma_ack), .dma_rvalid(dma_rvalid), .dma_di(dma_di), .dma_busy(dma_busy),
    .dma_done(dma_done), .dma_starve(dma_starve),
    .mem_a(mem_a), .mem_we(mem_we), .mem_do(mem_do), .mem_di(mem_di)
  );

  always #5 sys_clk = ~sys_clk;

  // Synchronous RAM, read-first; never-written words read as addr ^ 16'h5A5A.
  logic [15:0] ram     [65536];
  bit          ram_vld [65536];

  function automatic logic [15:0] ram_rd(input logic [15:0] a);
    return ram_vld[a] ? ram[a] : (a ^ 16'h5A5A);
  endfunction

  always @(posedge sys_clk) begin
    if (mem_we) begin
      ram[mem_a]     <= mem_do;
      ram_vld[mem_a] <= 1'b1;
    end
    mem_di <= ram_rd(mem_a);
  end

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Reference model: pending beat addresses of the open burst.
  bit          m_active = 1'b0;
  logic [15:0] m_q[$];
  bit          m_dir = 1'b0;
  int          m_stolen = 0;
  logic        e_rvalid = 1'b0, e_done = 1'b0, e_starve = 1'b0;
  logic [15:0] e_rdata = 16'h0;

  logic        s_ack, s_mwe, s_busy, s_done, s_rvalid, s_starve;
  logic [15:0] s_ma, s_mdo, s_di;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %b, expected %b", name, cyc, act, exp);
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, exp);
  endtask

  function automatic in_t mkin(input logic rst, re, we, input logic [15:0] ca, cd,
                               input logic req, dwe, input logic [15:0] da,
                               input logic [7:0] dl, input logic [15:0] ddo);
    in_t v;
    v.rst = rst; v.re = re; v.we = we; v.ca = ca; v.cd = cd;
    v.req = req; v.dwe = dwe; v.da = da; v.dl = dl; v.ddo = ddo;
    return v;
  endfunction

  function automatic in_t quiet();
    return mkin(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 8'h0, 16'h0);
  endfunction

  function automatic vec_t mkv(input in_t vi, input logic ack, input logic [15:0] ma,
                               input logic mwe, input logic [15:0] mdo,
                               input logic busy, input logic done);
    vec_t t;
    t.vi = vi; t.ack = ack; t.ma = ma; t.mwe = mwe; t.mdo = mdo; t.busy = busy; t.done = done;
    return t;
  endfunction

  // One clock cycle: drive, sample at negedge, compare against the model, advance the model.
  task automatic cycle(input in_t v);
    logic        ca, bt;
    logic [15:0] ba;
    sys_rst = v.rst; core_re = v.re; core_we = v.we; core_a = v.ca; core_do = v.cd;
    dma_req = v.req; dma_we = v.dwe; dma_a = v.da; dma_len = v.dl; dma_do = v.ddo;
    @(negedge sys_clk);
    s_ack = dma_ack; s_mwe = mem_we; s_busy = dma_busy; s_done = dma_done;
    s_rvalid = dma_rvalid; s_starve = dma_starve; s_ma = mem_a; s_mdo = mem_do; s_di = dma_di;
    ca = v.re | v.we;
    bt = m_active && !ca;
    ba = bt ? m_q[0] : 16'h0;
    chk1("ack", s_ack, bt);
    chk16("mem_a", s_ma, bt ? ba : v.ca);
    chk1("mem_we", s_mwe, bt ? m_dir : v.we);
    chk16("mem_do", s_mdo, bt ? v.ddo : v.cd);
    chk1("busy", s_busy, m_active);
    chk1("rvalid", s_rvalid, e_rvalid);
    if (e_rvalid) chk16("dma_di", s_di, e_rdata);
    chk1("done", s_done, e_done);
    chk1("starve", s_starve, e_starve);
    chk16("core_di", core_di, mem_di);
    if (s_done) $display("cycle %0d: burst complete", cyc);
    if (v.rst) begin
      m_active = 1'b0; m_q.delete(); m_stolen = 0;
      e_rvalid = 1'b0; e_done = 1'b0; e_starve = 1'b0;
    end else begin
      e_rvalid = bt && !m_dir;
      if (bt) e_rdata = ram_rd(ba);
      e_done = bt && (m_q.size() == 1);
      if (m_active) begin
        if (bt) begin
          void'(m_q.pop_front());
          m_stolen = 0;
          if (m_q.size() == 0) m_active = 1'b0;
        end else if (m_stolen < SM) begin
          m_stolen++;
        end
      end else begin
        m_stolen = 0;
        if (v.req) begin
          m_dir = v.dwe;
          for (int i = 0; i <= int'(v.dl); i++) m_q.push_back(v.da + 16'(i));
          m_active = 1'b1;
          $display("cycle %0d: burst accepted base=%h len=%0d we=%b", cyc, v.da, v.dl, v.dwe);
        end
      end
      e_starve = (m_stolen >= SM);
    end
    @(posedge sys_clk);
    #1;
    cyc++;
  endtask

  vec_t tbl[16];
  in_t  rv;
  int   core_run;
  int   kind;
  logic act;

  initial begin
    sys_rst = 1'b1; core_re = 0; core_we = 0; core_a = 0; core_do = 0;
    dma_req = 0; dma_we = 0; dma_a = 0; dma_len = 0; dma_do = 0;
    repeat (2) @(posedge sys_clk);
    #1;

    cycle(mkin(1, 0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 8'h0, 16'h0));
    cycle(quiet());
    chk1("rst_busy", s_busy, 1'b0);
    chk1("rst_ack", s_ack, 1'b0);
    chk1("rst_mem_we", s_mwe, 1'b0);
    chk1("rst_done", s_done, 1'b0);
    chk1("rst_starve", s_starve, 1'b0);
    chk1("rst_rvalid", s_rvalid, 1'b0);

    // Clean write burst, interrupted write burst, back-to-back single read.
    tbl[0]  = mkv(mkin(0,0,0,16'h0,16'h0,1,1,16'h0100,8'd3,16'hA000), 0, 16'h0000, 0, 16'h0000, 0, 0);
    tbl[1]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA001),    1, 16'h0100, 1, 16'hA001, 1, 0);
    tbl[2]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA002),    1, 16'h0101, 1, 16'hA002, 1, 0);
    tbl[3]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA003),    1, 16'h0102, 1, 16'hA003, 1, 0);
    tbl[4]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA004),    1, 16'h0103, 1, 16'hA004, 1, 0);
    tbl[5]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA005),    0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[6]  = mkv(mkin(0,0,0,16'h0,16'h0,1,1,16'h0300,8'd3,16'hA006), 0, 16'h0000, 0, 16'h0000, 0, 0);
    tbl[7]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA007),    1, 16'h0300, 1, 16'hA007, 1, 0);
    tbl[8]  = mkv(mkin(0,0,1,16'h0200,16'hBEEF,0,0,16'h0,8'd0,16'hA008), 0, 16'h0200, 1, 16'hBEEF, 1, 0);
    tbl[9]  = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA009),    1, 16'h0301, 1, 16'hA009, 1, 0);
    tbl[10] = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA00A),    1, 16'h0302, 1, 16'hA00A, 1, 0);
    tbl[11] = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA00B),    1, 16'h0303, 1, 16'hA00B, 1, 0);
    tbl[12] = mkv(mkin(0,0,0,16'h0,16'h0,1,0,16'h0010,8'd0,16'hA00C), 0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[13] = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA00D),    1, 16'h0010, 0, 16'hA00D, 1, 0);
    tbl[14] = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA00E),    0, 16'h0000, 0, 16'h0000, 0, 1);
    tbl[15] = mkv(mkin(0,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'hA00F),    0, 16'h0000, 0, 16'h0000, 0, 0);
    for (int r = 0; r < 16; r++) begin
      cycle(tbl[r].vi);
      chk1($sformatf("tbl%0d_ack", r), s_ack, tbl[r].ack);
      chk16($sformatf("tbl%0d_mem_a", r), s_ma, tbl[r].ma);
      chk1($sformatf("tbl%0d_mem_we", r), s_mwe, tbl[r].mwe);
      chk16($sformatf("tbl%0d_mem_do", r), s_mdo, tbl[r].mdo);
      chk1($sformatf("tbl%0d_busy", r), s_busy, tbl[r].busy);
      chk1($sformatf("tbl%0d_done", r), s_done, tbl[r].done);
    end

    // Read burst wrapping through 0xFFFF.
    cycle(mkin(0,0,0,16'h0,16'h0,1,0,16'hFFFE,8'd2,16'h0));
    cycle(quiet());
    chk1("wrap_ack0", s_ack, 1'b1);
    chk16("wrap_a0", s_ma, 16'hFFFE);
    cycle(quiet());
    chk16("wrap_a1", s_ma, 16'hFFFF);
    chk1("wrap_rv0", s_rvalid, 1'b1);
    chk16("wrap_d0", s_di, 16'hA5A4);
    cycle(quiet());
    chk16("wrap_a2", s_ma, 16'h0000);
    chk16("wrap_d1", s_di, 16'hA5A5);
    cycle(quiet());
    chk1("wrap_rv2", s_rvalid, 1'b1);
    chk16("wrap_d2", s_di, 16'h5A5A);
    chk1("wrap_done", s_done, 1'b1);
    chk1("wrap_busy", s_busy, 1'b0);

    // Starvation: six stolen cycles, then two beats.
    cycle(mkin(0,0,0,16'h0,16'h0,1,1,16'h0400,8'd1,16'h0));
    for (int k = 1; k <= 6; k++) begin
      cycle(mkin(0,1,0,16'h0800,16'h0,0,0,16'h0,8'd0,16'h0));
      chk1($sformatf("starve_k%0d", k), s_starve, k >= 5);
      chk1($sformatf("starve_ack_k%0d", k), s_ack, 1'b0);
    end
    cycle(quiet());
    chk1("starve_beat1_ack", s_ack, 1'b1);
    chk1("starve_beat1_flag", s_starve, 1'b1);
    cycle(quiet());
    chk1("starve_beat2_ack", s_ack, 1'b1);
    chk1("starve_cleared", s_starve, 1'b0);
    cycle(quiet());
    chk1("starve_done", s_done, 1'b1);

    // Reset in the middle of an 8-beat read.
    cycle(mkin(0,0,0,16'h0,16'h0,1,0,16'h0500,8'd7,16'h0));
    cycle(quiet());
    cycle(quiet());
    cycle(mkin(1,0,0,16'h0,16'h0,0,0,16'h0,8'd0,16'h0));
    cycle(quiet());
    chk1("mrst_busy", s_busy, 1'b0);
    chk1("mrst_rvalid", s_rvalid, 1'b0);
    chk1("mrst_done", s_done, 1'b0);
    chk1("mrst_ack", s_ack, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(quiet());
      chk1($sformatf("mrst_rvalid_%0d", k), s_rvalid, 1'b0);
      chk1($sformatf("mrst_ack_%0d", k), s_ack, 1'b0);
    end

    // Randomized traffic against the model.
    core_run = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 19) == 0) core_run = $urandom_range(0, 7);
      if (core_run > 0) begin
        act = 1'b1;
        core_run--;
      end else begin
        act = ($urandom_range(0, 2) == 0);
      end
      kind = $urandom_range(0, 2);
      rv.rst = ($urandom_range(0, 299) == 0);
      rv.re  = act && (kind != 1);
      rv.we  = act && (kind != 0);
      rv.ca  = 16'($urandom);
      rv.cd  = 16'($urandom);
      rv.req = ($urandom_range(0, 3) == 0);
      rv.dwe = 1'($urandom_range(0, 1));
      rv.da  = ($urandom_range(0, 3) == 0) ? 16'(16'hFFF8 + $urandom_range(0, 7)) : 16'($urandom);
      rv.dl  = 8'($urandom_range(0, 15));
      rv.ddo = 16'($urandom);
      cycle(rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/d16_dbus_arbiter.md
Name: d16_dbus_arbiter

Overview:
- Shares the single synchronous data RAM port between the d16 core data bus and a burst DMA requester (loader/debug/peripheral copy).
- The core pipeline cannot stall on data accesses, so the core always has absolute priority.
- DMA beats are issued only in cycles where the core makes no access. The block sequences DMA bursts (address generation, beat count) and tracks DMA starvation.

Parameters:
- STARVE_MAX, 255, consecutive stolen cycles within a burst before dma_starve asserts; 1..65535.
- CNT_W, 16, width of the starvation counter; must hold STARVE_MAX.

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  synchronous reset, active high
- core_re  in  1  core read access this cycle (LOD/LOP in EX/MEM stage)
- core_we  in  1  core write access this cycle (STR/STP)
- core_a  in  16  core address
- core_do  in  16  core write data
- core_di  out  16  core read data; equals mem_di
- dma_req  in  1  start burst; sampled in IDLE only
- dma_we  in  1  burst direction (1 = write), sampled with dma_req
- dma_a  in  16  burst base address, sampled with dma_req
- dma_len  in  8  beats minus one, sampled with dma_req
- dma_do  in  16  write data for the current beat
- dma_ack  out  1  beat issued this cycle; requester advances dma_do on the next cycle
- dma_rvalid  out  1  DMA read data valid on dma_di
- dma_di  out  16  DMA read data; equals mem_di
- dma_busy  out  1  high in BURST
- dma_done  out  1  one-cycle pulse after the final beat
- dma_starve  out  1  starvation flag
- mem_a  out  16  RAM address
- mem_we  out  1  RAM write enable
- mem_do  out  16  RAM write data
- mem_di  in  16  RAM read data, valid one cycle after its address

Behaviour:
- RAM timing: synchronous. Address and we are sampled at a clock edge; read data appears on mem_di the following cycle.
- Reset: state = IDLE; beat counter, index and starvation count = 0. Registered outputs dma_rvalid, dma_done and dma_starve = 0. dma_ack = 0, dma_busy = 0, mem_we = 0.
- Core path is combinational, zero added latency:
  - core_act = core_re | core_we.
  - When core_act = 1: mem_a = core_a, mem_we = core_we, mem_do = core_do.
  - core_re and core_we both high: treat as a write.
  - When core_act = 0 and no DMA beat is issued: mem_a = core_a, mem_we = 0, mem_do = core_do.
- FSM states: IDLE, BURST.
- IDLE:
  - dma_req = 1 latches base = dma_a, dir = dma_we, remaining = dma_len, idx = 0, then goes to BURST.
  - No beat is issued in the same cycle, so the first beat is earliest at N+1 for a request at cycle N.
- BURST beat rules:
  - A beat is issued in any cycle with core_act = 0.
  - On a beat: mem_a = base + idx (mod 2^16, wraps 0xFFFF -> 0x0000), mem_we = dir, mem_do = dma_do, dma_ack = 1 (combinational).
  - After a beat: idx++, remaining--.
  - Final beat is the one issued with remaining = 0: next state IDLE, dma_done = 1 the following cycle.
  - Cycles with core_act = 1 issue no beat; dma_ack = 0.
  - dma_req is ignored while in BURST.
- Reads: dma_rvalid is registered, high in the cycle after each read beat (dir = 0); dma_di = mem_di. For the last read beat, dma_done and the final dma_rvalid coincide.
- Writes: dma_rvalid is never asserted.
- dma_busy = (state == BURST).
- Starvation counter (BURST only):
  - Increments each cycle with core_act = 1, saturating at STARVE_MAX.
  - Clears on every issued beat and in IDLE.
  - dma_starve is registered high while count == STARVE_MAX. It drops the cycle after the next beat issues or the counter clears.
- Back-to-back bursts: a new dma_req in the cycle dma_done is high is accepted (the state is already IDLE then). No beat is issued that cycle.
- Reset mid-burst: returns to IDLE immediately. No dma_done, no pending dma_rvalid. Subsequent RAM read data is not reported.
- The core is never delayed. A DMA beat never coincides with a core access (mem_we cannot come from both sources).

Test Plan:
- Reset, then idle bus with core_act = 0 -> dma_busy = 0, dma_ack = 0, mem_we = 0, dma_done = 0, dma_starve = 0.
- DMA write burst with dma_a = 0x0100, dma_len = 3, dma_we = 1, core quiet -> acks on cycles N+1..N+4; mem_a = 0x0100..0x0103 with mem_we = 1; dma_done pulse at N+5.
- DMA read burst with dma_a = 0xFFFE, dma_len = 2, RAM preloaded -> mem_a = 0xFFFE, 0xFFFF, 0x0000; dma_rvalid one cycle after each beat with the matching data; dma_done coincides with the third dma_rvalid.
- During a 4-beat write, core_we = 1 at core_a = 0x0200 on the 2nd beat cycle -> mem_a = 0x0200 with core data, dma_ack = 0; the remaining beats shift by one cycle; done at N+6.
- STARVE_MAX = 4, core_act held high for 6 cycles in BURST -> dma_starve rises after the 4th stolen cycle, stays high, and clears the cycle after the next issued beat.
- sys_rst asserted after the 2nd beat of an 8-beat read -> next cycle IDLE, dma_busy = 0, no dma_done, no further dma_rvalid.
